// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I-subset controller:
// FSM states, opcodes, ALU operation codes and the instruction classifier.
package ctrl_pkg;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_e;

  typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_BEQ, C_BAD} iclass_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // funct3 011 (SLTU) is not part of the supported subset for R/I
  function automatic iclass_e classify(input logic [6:0] opcode, input logic [2:0] funct3);
    iclass_e cls;
    cls = C_BAD;
    case (opcode)
      OP_R:   if (funct3 != 3'b011) cls = C_R;
      OP_I:   if (funct3 != 3'b011) cls = C_I;
      OP_LW:  if (funct3 == 3'b010) cls = C_LW;
      OP_SW:  if (funct3 == 3'b010) cls = C_SW;
      OP_BEQ: if (funct3 == 3'b000) cls = C_BEQ;
      default: cls = C_BAD;
    endcase
    return cls;
  endfunction

  function automatic logic [3:0] ex_alu_op(input iclass_e cls, input logic [2:0] funct3,
                                           input logic bit30);
    logic [3:0] op;
    op = ALU_ADD;
    case (cls)
      C_BEQ: op = ALU_SUB;
      C_R, C_I: begin
        case (funct3)
          3'b000: op = (cls == C_R && bit30) ? ALU_SUB : ALU_ADD;
          3'b001: op = ALU_SLL;
          3'b010: op = ALU_SLT;
          3'b100: op = ALU_XOR;
          3'b101: op = bit30 ? ALU_SRA : ALU_SRL;
          3'b110: op = ALU_OR;
          3'b111: op = ALU_AND;
          default: op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended immediate extraction from the instruction register.
// Takes only IR[31:20] and IR[11:7], which carry every I/S/B immediate bit.
module imm_gen
  import ctrl_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic [11:0]          ir_hi_i,
  input  logic [4:0]           ir_lo_i,
  input  iclass_e              cls_i,
  output logic [DATAWIDTH-1:0] imm_o
);

  logic [11:0] s_imm;
  logic [12:0] b_imm;

  assign s_imm = {ir_hi_i[11:5], ir_lo_i};
  assign b_imm = {ir_hi_i[11], ir_lo_i[0], ir_hi_i[10:5], ir_lo_i[4:1], 1'b0};

  always_comb begin
    imm_o = '0;
    case (cls_i)
      C_I, C_LW: imm_o = {{(DATAWIDTH-12){ir_hi_i[11]}}, ir_hi_i};
      C_SW:      imm_o = {{(DATAWIDTH-12){s_imm[11]}}, s_imm};
      C_BEQ:     imm_o = {{(DATAWIDTH-13){b_imm[12]}}, b_imm};
      default:   imm_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Instruction register and multicycle IF/ID/EX/MEM/WB control FSM.
// Define INSTR_CNT_EN to add the retired-instruction counter output instret.
//
//   state | meaning
//   S_IF  | instruction memory valid; IR loads on exit
//   S_ID  | decode; flags undecodable instructions and retires them
//   S_EX  | ALU operation; BEQ resolves and retires here
//   S_MEM | data memory access; SW retires here
//   S_WB  | register file write-back; R/I/LW retire here
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] instr,
  input  logic                 zero,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic [DATAWIDTH-1:0] imm,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 alu_src,
  output logic [3:0]           alu_op,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 illegal
`ifdef INSTR_CNT_EN
  ,
  output logic [31:0]          instret
`endif
);

  state_e               state_q;
  logic [DATAWIDTH-1:0] ir_q;
  logic                 reg_write_q, mem_to_reg_q, alu_src_q;
  logic [3:0]           alu_op_q;
  logic                 mem_read_q, mem_write_q, pc_write_q, beq_ex_q, illegal_q;

  iclass_e ir_cls, instr_cls;
  logic    rd_nz;

  assign ir_cls    = classify(ir_q[6:0], ir_q[14:12]);
  assign instr_cls = classify(instr[6:0], instr[14:12]);
  assign rd_nz     = (ir_q[11:7] != 5'd0);

  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign rd  = ir_q[11:7];

  imm_gen #(.DATAWIDTH(DATAWIDTH)) u_imm_gen (
    .ir_hi_i (ir_q[31:20]),
    .ir_lo_i (ir_q[11:7]),
    .cls_i   (ir_cls),
    .imm_o   (imm)
  );

  // Outputs are registered for the state being entered, so each is valid for that whole state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IF;
      ir_q         <= NOP_INSTR;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= ALU_ADD;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      pc_write_q   <= 1'b0;
      beq_ex_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= ALU_ADD;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      pc_write_q   <= 1'b0;
      beq_ex_q     <= 1'b0;
      illegal_q    <= 1'b0;
      case (state_q)
        S_IF: begin
          ir_q    <= instr;
          state_q <= S_ID;
          if (instr_cls == C_BAD) begin
            illegal_q  <= 1'b1;
            pc_write_q <= 1'b1;
          end
        end
        S_ID: begin
          if (ir_cls == C_BAD) begin
            state_q <= S_IF;
          end else begin
            state_q   <= S_EX;
            alu_src_q <= (ir_cls == C_I) || (ir_cls == C_LW) || (ir_cls == C_SW);
            alu_op_q  <= ex_alu_op(ir_cls, ir_q[14:12], ir_q[30]);
            if (ir_cls == C_BEQ) begin
              pc_write_q <= 1'b1;
              beq_ex_q   <= 1'b1;
            end
          end
        end
        S_EX: begin
          case (ir_cls)
            C_LW: begin
              state_q    <= S_MEM;
              mem_read_q <= 1'b1;
            end
            C_SW: begin
              state_q     <= S_MEM;
              mem_write_q <= 1'b1;
              pc_write_q  <= 1'b1;
            end
            C_R, C_I: begin
              state_q     <= S_WB;
              reg_write_q <= rd_nz;
              pc_write_q  <= 1'b1;
            end
            default: state_q <= S_IF;
          endcase
        end
        S_MEM: begin
          if (ir_cls == C_LW) begin
            state_q      <= S_WB;
            reg_write_q  <= rd_nz;
            mem_to_reg_q <= 1'b1;
            pc_write_q   <= 1'b1;
          end else begin
            state_q <= S_IF;
          end
        end
        default: state_q <= S_IF;
      endcase
    end
  end

  assign reg_write  = reg_write_q;
  assign mem_to_reg = mem_to_reg_q;
  assign alu_src    = alu_src_q;
  assign alu_op     = alu_op_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign pc_write   = pc_write_q;
  assign illegal    = illegal_q;
  // zero is only known during EX itself, so the branch decision cannot be pre-registered
  assign pc_src     = beq_ex_q & zero;

`ifdef INSTR_CNT_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (pc_write_q && !illegal_q) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed test-plan scenarios plus
// randomized instructions checked against a cycle-count based reference model.
module tb_multicycle_ctrl;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
  localparam logic [3:0] SLT = 4'd5, SLL = 4'd6, SRL = 4'd7, SRA = 4'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0000_0013;
  logic        zero = 1'b0;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        reg_write, mem_to_reg, alu_src, mem_read, mem_write, pc_write, pc_src, illegal;
  logic [3:0]  alu_op;
`ifdef INSTR_CNT_EN
  logic [31:0] instret;
`endif

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.DATAWIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .imm        (imm),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .illegal    (illegal)
`ifdef INSTR_CNT_EN
    ,
    .instret    (instret)
`endif
  );

  always #5 clk = ~clk;

  // {reg_write, mem_to_reg, alu_src, alu_op[3:0], mem_read, mem_write, pc_write, pc_src, illegal}
  function automatic logic [11:0] ctl(input bit rw, input bit mtr, input bit as, input logic [3:0] op,
                                      input bit mr, input bit mw, input bit pw, input bit ps, input bit il);
    return {rw, mtr, as, op, mr, mw, pw, ps, il};
  endfunction

  function automatic logic [11:0] obs();
    return {reg_write, mem_to_reg, alu_src, alu_op, mem_read, mem_write, pc_write, pc_src, illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef enum {K_R, K_I, K_LW, K_SW, K_BEQ, K_BAD} kind_t;

  function automatic kind_t kind_of(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    if (op == 7'b0110011 && f3 != 3'd3) return K_R;
    if (op == 7'b0010011 && f3 != 3'd3) return K_I;
    if (op == 7'b0000011 && f3 == 3'd2) return K_LW;
    if (op == 7'b0100011 && f3 == 3'd2) return K_SW;
    if (op == 7'b1100011 && f3 == 3'd0) return K_BEQ;
    return K_BAD;
  endfunction

  function automatic int n_cycles(input kind_t k);
    case (k)
      K_R, K_I: return 4;
      K_LW:     return 5;
      K_SW:     return 4;
      K_BEQ:    return 3;
      default:  return 2;
    endcase
  endfunction

  function automatic logic [3:0] m_alu(input logic [31:0] w, input kind_t k);
    logic [3:0] tbl [8];
    tbl = '{ADD, SLL, SLT, ADD, XOR_, SRL, OR_, AND_};
    if (k == K_LW || k == K_SW) return ADD;
    if (k == K_BEQ) return SUB;
    if (w[14:12] == 3'd0 && k == K_R && w[30]) return SUB;
    if (w[14:12] == 3'd5 && w[30]) return SRA;
    return tbl[w[14:12]];
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] w, input kind_t k);
    int v;
    case (k)
      K_I, K_LW: v = int'(signed'(w[31:20]));
      K_SW:      v = int'(signed'({w[31:25], w[11:7]}));
      K_BEQ:     v = int'(signed'({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      default:   v = 0;
    endcase
    return 32'(v);
  endfunction

  // expected controls in cycle cyc (1 = IF) of the instruction w
  function automatic logic [11:0] m_ctl(input logic [31:0] w, input bit z, input int cyc);
    kind_t k;
    int    last;
    bit    writes_rd;
    k    = kind_of(w);
    last = n_cycles(k);
    writes_rd = (k == K_R || k == K_I || k == K_LW);
    return ctl(cyc == last && writes_rd && w[11:7] != 5'd0,
               k == K_LW && cyc == 5,
               cyc == 3 && (k == K_I || k == K_LW || k == K_SW),
               (cyc == 3 && k != K_BAD) ? m_alu(w, k) : ADD,
               k == K_LW && cyc == 4,
               k == K_SW && cyc == 4,
               cyc == last,
               k == K_BEQ && cyc == 3 && z,
               k == K_BAD && cyc == 2);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 12'h000) begin
      errors++; $display("FAIL reset_ctl got=%h want=%h", obs(), 12'h000);
    end
    checks++;
    if ({rs1, rs2, rd, imm} !== 47'd0) begin
      errors++; $display("FAIL reset_ir_nop got rs1=%0d rs2=%0d rd=%0d imm=%h want all 0", rs1, rs2, rd, imm);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_add();
    instr = 32'h0020_81B3;
    checks++;
    if (obs() !== 12'h000) begin errors++; $display("FAIL add_c1 got=%h want=%h", obs(), 12'h000); end
    step();
    checks++;
    if ({rs1, rs2, rd} !== {5'd1, 5'd2, 5'd3}) begin
      errors++; $display("FAIL add_regs got=%0d/%0d/%0d want=1/2/3", rs1, rs2, rd);
    end
    checks++;
    if (obs() !== 12'h000) begin errors++; $display("FAIL add_c2 got=%h want=%h", obs(), 12'h000); end
    step();
    checks++;
    if (obs() !== ctl(0,0,0,ADD,0,0,0,0,0)) begin
      errors++; $display("FAIL add_c3 got=%h want=%h", obs(), ctl(0,0,0,ADD,0,0,0,0,0));
    end
    step();
    checks++;
    if (obs() !== ctl(1,0,0,ADD,0,0,1,0,0)) begin
      errors++; $display("FAIL add_c4 got=%h want=%h", obs(), ctl(1,0,0,ADD,0,0,1,0,0));
    end
    step();
    checks++;
    if (obs() !== 12'h000) begin errors++; $display("FAIL add_c5 got=%h want=%h", obs(), 12'h000); end
  endtask

  task automatic test_lw();
    instr = 32'h0081_2283;
    step();
    checks++;
    if ({rd, imm} !== {5'd5, 32'h8}) begin
      errors++; $display("FAIL lw_fields got rd=%0d imm=%h want rd=5 imm=00000008", rd, imm);
    end
    step();
    checks++;
    if (obs() !== ctl(0,0,1,ADD,0,0,0,0,0)) begin
      errors++; $display("FAIL lw_c3 got=%h want=%h", obs(), ctl(0,0,1,ADD,0,0,0,0,0));
    end
    step();
    checks++;
    if (obs() !== ctl(0,0,0,ADD,1,0,0,0,0)) begin
      errors++; $display("FAIL lw_c4 got=%h want=%h", obs(), ctl(0,0,0,ADD,1,0,0,0,0));
    end
    step();
    checks++;
    if (obs() !== ctl(1,1,0,ADD,0,0,1,0,0)) begin
      errors++; $display("FAIL lw_c5 got=%h want=%h", obs(), ctl(1,1,0,ADD,0,0,1,0,0));
    end
    step();
  endtask

  task automatic test_sw();
    instr = 32'h0051_2623;
    step();
    checks++;
    if (imm !== 32'h0000_000C) begin errors++; $display("FAIL sw_imm got=%h want=0000000c", imm); end
    step();
    checks++;
    if (obs() !== ctl(0,0,1,ADD,0,0,0,0,0)) begin
      errors++; $display("FAIL sw_c3 got=%h want=%h", obs(), ctl(0,0,1,ADD,0,0,0,0,0));
    end
    step();
    checks++;
    if (obs() !== ctl(0,0,0,ADD,0,1,1,0,0)) begin
      errors++; $display("FAIL sw_c4 got=%h want=%h", obs(), ctl(0,0,0,ADD,0,1,1,0,0));
    end
    step();
    checks++;
    if (obs() !== 12'h000) begin errors++; $display("FAIL sw_c5 got=%h want=%h", obs(), 12'h000); end
  endtask

  task automatic test_beq(input bit z);
    instr = 32'h0020_8863;
    zero  = z;
    step();
    checks++;
    if (imm !== 32'h0000_0010) begin errors++; $display("FAIL beq_imm got=%h want=00000010", imm); end
    step();
    checks++;
    if (obs() !== ctl(0,0,0,SUB,0,0,1,z,0)) begin
      errors++; $display("FAIL beq_c3_z%0d got=%h want=%h", z, obs(), ctl(0,0,0,SUB,0,0,1,z,0));
    end
    step();
    checks++;
    if (obs() !== 12'h000) begin errors++; $display("FAIL beq_c4 got=%h want=%h", obs(), 12'h000); end
    zero = 1'b0;
  endtask

  task automatic test_x0_write();
    instr = 32'h0010_0013;
    repeat (3) step();
    checks++;
    if (obs() !== ctl(0,0,0,ADD,0,0,1,0,0)) begin
      errors++; $display("FAIL x0_wb got=%h want=%h", obs(), ctl(0,0,0,ADD,0,0,1,0,0));
    end
    step();
  endtask

  task automatic test_illegal();
    instr = 32'hFFFF_FFFF;
    step();
    checks++;
    if (obs() !== ctl(0,0,0,ADD,0,0,1,0,1)) begin
      errors++; $display("FAIL illegal_id got=%h want=%h", obs(), ctl(0,0,0,ADD,0,0,1,0,1));
    end
    step();
    checks++;
    if (obs() !== 12'h000) begin errors++; $display("FAIL illegal_next got=%h want=%h", obs(), 12'h000); end
  endtask

  task automatic test_reset_mid();
    instr = 32'h0081_2283;
    repeat (3) step();
    checks++;
    if (mem_read !== 1'b1) begin errors++; $display("FAIL rstmid_mem got=%b want=1", mem_read); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 12'h000) begin errors++; $display("FAIL rstmid_async got=%h want=%h", obs(), 12'h000); end
    @(posedge clk);
    #2 rst = 1'b0;
    checks++;
    if (obs() !== 12'h000 || rd !== 5'd0) begin
      errors++; $display("FAIL rstmid_after got=%h rd=%0d want=%h rd=0", obs(), rd, 12'h000);
    end
    test_add();
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [2:0]  f3;
    bit          z;
    kind_t       k;
    int          last;
`ifdef INSTR_CNT_EN
    logic [31:0] exp_ret;
    exp_ret = 32'd1;
`endif
    for (int n = 0; n < 80; n++) begin
      w  = $urandom;
      z  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 6));
      if (f3 >= 3'd3) f3 = f3 + 3'd1;
      case ($urandom_range(0, 5))
        0: begin w[6:0] = 7'b0110011; w[14:12] = f3; end
        1: begin w[6:0] = 7'b0010011; w[14:12] = f3; end
        2: begin w[6:0] = 7'b0000011; w[14:12] = 3'd2; end
        3: begin w[6:0] = 7'b0100011; w[14:12] = 3'd2; end
        4: begin w[6:0] = 7'b1100011; w[14:12] = 3'd0; end
        default: begin
          case ($urandom_range(0, 2))
            0: w[6:0] = 7'b1111111;
            1: begin w[6:0] = 7'b0110011; w[14:12] = 3'd3; end
            default: begin w[6:0] = 7'b0000011; w[14:12] = 3'd0; end
          endcase
        end
      endcase
      k     = kind_of(w);
      last  = n_cycles(k);
      instr = w;
      zero  = z;
      for (int c = 1; c <= last; c++) begin
        checks++;
        if (obs() !== m_ctl(w, z, c)) begin
          errors++; $display("FAIL rand_ctl n=%0d instr=%h cyc=%0d got=%h want=%h", n, w, c, obs(), m_ctl(w, z, c));
        end
        if (c >= 2) begin
          checks++;
          if ({rs1, rs2, rd} !== {w[19:15], w[24:20], w[11:7]}) begin
            errors++; $display("FAIL rand_regs n=%0d instr=%h got=%h want=%h", n, w, {rs1, rs2, rd}, {w[19:15], w[24:20], w[11:7]});
          end
          if (k != K_BAD) begin
            checks++;
            if (imm !== m_imm(w, k)) begin
              errors++; $display("FAIL rand_imm n=%0d instr=%h got=%h want=%h", n, w, imm, m_imm(w, k));
            end
          end
        end
        step();
        instr = $urandom;
      end
`ifdef INSTR_CNT_EN
      if (k != K_BAD) exp_ret = exp_ret + 32'd1;
      checks++;
      if (instret !== exp_ret) begin
        errors++; $display("FAIL rand_instret n=%0d got=%0d want=%0d", n, instret, exp_ret);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_x0_write();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
